// File: rtl/soc_timer_sched_pkg.sv
// rtl/soc_timer_sched_pkg.sv - shared types and the wrap-safe deadline test for the alarm scheduler
package soc_timer_sched_pkg;

  typedef enum logic {SLOT_IDLE = 1'b0, SLOT_ARMED = 1'b1} slot_state_t;

  localparam int MAX_SLOTS  = 16;
  localparam int DEADLINE_W = 32;

  // Signed difference keeps the test correct across count wrap for delays below 2^31.
  function automatic logic deadline_expired(input logic [DEADLINE_W-1:0] count,
                                            input logic [DEADLINE_W-1:0] deadline);
    logic [DEADLINE_W-1:0] diff;
    diff = count - deadline;
    return ($signed(diff) >= 0);
  endfunction

endpackage

// File: rtl/soc_timer_sched_slot.sv
// rtl/soc_timer_sched_slot.sv - one virtual alarm: state, deadline, arm/cancel/fire-ack handling
module soc_timer_sched_slot
  import soc_timer_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  res,
  input  logic [DEADLINE_W-1:0] timer_count,
  input  logic                  arm_valid,
  output logic                  arm_ready,
  input  logic [DEADLINE_W-1:0] arm_delay,
  input  logic                  cancel,
  input  logic                  fire_ack,
  output logic                  armed,
  output logic [DEADLINE_W-1:0] deadline
);

  slot_state_t           state;
  logic [DEADLINE_W-1:0] eff_delay;

  // A zero delay would alias "already expired" with "just armed", so it is bumped to one tick.
  assign eff_delay = (arm_delay == '0) ? DEADLINE_W'(1) : arm_delay;
  assign arm_ready = (state == SLOT_IDLE) & ~res;
  assign armed     = (state == SLOT_ARMED);

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= SLOT_IDLE;
      deadline <= '0;
    end else begin
      case (state)
        SLOT_IDLE: begin
          if (arm_valid) begin
            state    <= SLOT_ARMED;
            deadline <= timer_count + eff_delay;
          end
        end
        SLOT_ARMED: begin
          if (cancel || fire_ack) state <= SLOT_IDLE;
        end
        default: state <= SLOT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/soc_timer_alarm_sched.sv
// rtl/soc_timer_alarm_sched.sv - round-robin compare engine sharing one timer count across alarm slots
module soc_timer_alarm_sched
  import soc_timer_sched_pkg::*;
#(
  parameter int SLOT_COUNT = 4
) (
  input  logic                                  clk,
  input  logic                                  res,
  input  logic [DEADLINE_W-1:0]                 timer_count,
  input  logic [SLOT_COUNT-1:0]                 arm_valid,
  output logic [SLOT_COUNT-1:0]                 arm_ready,
  input  logic [SLOT_COUNT-1:0][DEADLINE_W-1:0] arm_delay,
  input  logic [SLOT_COUNT-1:0]                 cancel,
  output logic [SLOT_COUNT-1:0]                 armed,
  output logic [SLOT_COUNT-1:0]                 fire,
  output logic [SLOT_COUNT-1:0]                 irq_pending,
  input  logic [SLOT_COUNT-1:0]                 irq_clear,
  output logic                                  interrupt_trigger
);

  localparam int PW = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;

  if (SLOT_COUNT < 1 || SLOT_COUNT > MAX_SLOTS) begin : g_bad_slot_count
    $error("soc_timer_alarm_sched: SLOT_COUNT must be in 1..16");
  end

  logic [PW-1:0]         scan_ptr;
  logic [DEADLINE_W-1:0] deadline [SLOT_COUNT];
  logic [DEADLINE_W-1:0] sel_deadline;
  logic                  sel_armed;
  logic                  sel_cancel;
  logic                  hit;
  logic [SLOT_COUNT-1:0] hit_vec;
  logic [SLOT_COUNT-1:0] fire_q;
  logic                  trig_q;

  for (genvar i = 0; i < SLOT_COUNT; i++) begin : g_slot
    soc_timer_sched_slot u_slot (
      .clk         (clk),
      .res         (res),
      .timer_count (timer_count),
      .arm_valid   (arm_valid[i]),
      .arm_ready   (arm_ready[i]),
      .arm_delay   (arm_delay[i]),
      .cancel      (cancel[i]),
      .fire_ack    (hit_vec[i]),
      .armed       (armed[i]),
      .deadline    (deadline[i])
    );
  end

  always_comb begin
    sel_deadline = '0;
    sel_armed    = 1'b0;
    sel_cancel   = 1'b0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      if (scan_ptr == PW'(i)) begin
        sel_deadline = deadline[i];
        sel_armed    = armed[i];
        sel_cancel   = cancel[i];
      end
    end
  end

  // A cancel arriving in the scan cycle suppresses the fire outright.
  assign hit = sel_armed & ~sel_cancel & deadline_expired(timer_count, sel_deadline);

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < SLOT_COUNT; i++) hit_vec[i] = hit && (scan_ptr == PW'(i));
  end

  always_ff @(posedge clk) begin
    if (res) begin
      scan_ptr    <= '0;
      fire_q      <= '0;
      trig_q      <= 1'b0;
      irq_pending <= '0;
    end else begin
      scan_ptr <= (scan_ptr == PW'(SLOT_COUNT - 1)) ? '0 : scan_ptr + PW'(1);
      fire_q   <= hit_vec;
      trig_q   <= hit;
      // A clear coinciding with a fire (scan cycle or pulse cycle) leaves the bit set.
      irq_pending <= (irq_pending & ~(irq_clear & ~fire_q)) | hit_vec;
    end
  end

  assign fire              = fire_q & {SLOT_COUNT{~res}};
  assign interrupt_trigger = trig_q & ~res;

endmodule

// File: tb/tb_soc_timer_alarm_sched.sv
// tb/tb_soc_timer_alarm_sched.sv - directed self-checking bench for the alarm scheduler
module tb_soc_timer_alarm_sched;

  logic             clk = 1'b0;
  logic             res;
  logic [31:0]      timer_count;
  logic [3:0]       arm_valid;
  logic [3:0]       arm_ready;
  logic [3:0][31:0] arm_delay;
  logic [3:0]       cancel;
  logic [3:0]       armed;
  logic [3:0]       fire;
  logic [3:0]       irq_pending;
  logic [3:0]       irq_clear;
  logic             interrupt_trigger;

  int          passed = 0;
  int          failed = 0;
  int          total  = 0;
  int          fire_cnt [4];
  logic [31:0] fire_tc [4];
  int          itrig_cnt;
  int          fire_order [$];
  int          ptr_model;
  bit          cnt_en;
  logic [31:0] watch_tc;
  int          watch_ptr;
  logic [31:0] c0;
  logic [31:0] dl;
  int          guard;

  always #5 clk = ~clk;

  soc_timer_alarm_sched #(.SLOT_COUNT(4)) dut (
    .clk               (clk),
    .res               (res),
    .timer_count       (timer_count),
    .arm_valid         (arm_valid),
    .arm_ready         (arm_ready),
    .arm_delay         (arm_delay),
    .cancel            (cancel),
    .armed             (armed),
    .fire              (fire),
    .irq_pending       (irq_pending),
    .irq_clear         (irq_clear),
    .interrupt_trigger (interrupt_trigger)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    for (int i = 0; i < 4; i++) begin
      fire_cnt[i] = 0;
      fire_tc[i]  = '0;
    end
    itrig_cnt = 0;
    fire_order.delete();
  endtask

  // One clock: observe outputs at the falling edge, then advance the pointer model and the count.
  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (fire[i]) begin
        fire_cnt[i]++;
        fire_tc[i] = timer_count;
        fire_order.push_back(i);
      end
    end
    if (interrupt_trigger) itrig_cnt++;
    if (timer_count == watch_tc) watch_ptr = ptr_model;
    @(posedge clk);
    ptr_model = res ? 0 : (ptr_model + 1) % 4;
    #1;
    if (cnt_en) timer_count = timer_count + 32'd1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  // Step until the slot is scanned in a cycle where its deadline has been reached.
  task automatic seek_scan(input int slot, input logic [31:0] d, input string tag);
    guard = 0;
    while (!(ptr_model == slot && timer_count >= d) && guard < 20) begin
      cyc();
      guard++;
    end
    check(tag, 32'(guard < 20), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    res = 1'b1; timer_count = 32'd100; cnt_en = 1'b0;
    arm_valid = '0; cancel = '0; irq_clear = '0; arm_delay = '0;
    watch_tc = 32'hDEAD_BEEF; watch_ptr = -1; ptr_model = 0;
    clr_stats();

    #1;
    check("rst_arm_ready_in_res", 32'(arm_ready), 32'h0);
    run(2);
    check("rst_fire_in_res", 32'(fire), 32'h0);
    res = 1'b0;
    #1;
    check("rst_armed", 32'(armed), 32'h0);
    check("rst_irq_pending", 32'(irq_pending), 32'h0);
    check("rst_fire", 32'(fire), 32'h0);
    check("rst_trigger", 32'(interrupt_trigger), 32'h0);
    check("rst_arm_ready", 32'(arm_ready), 32'hF);

    // Basic fire: count 100, slot 2, delay 10 -> deadline 110.
    cnt_en = 1'b1;
    arm_valid = 4'b0100; arm_delay[2] = 32'd10;
    clr_stats();
    cyc();
    arm_valid = '0;
    check("basic_armed", 32'(armed), 32'h4);
    check("basic_arm_ready", 32'(arm_ready), 32'hB);
    run(20);
    check("basic_fire_count", 32'(fire_cnt[2]), 32'd1);
    check("basic_trigger_count", 32'(itrig_cnt), 32'd1);
    check("basic_latency", 32'(fire_tc[2] >= 32'd111 && fire_tc[2] <= 32'd114), 32'd1);
    check("basic_irq_pending", 32'(irq_pending), 32'h4);
    check("basic_arm_ready_after", 32'(arm_ready), 32'hF);
    check("basic_armed_after", 32'(armed), 32'h0);

    // Zero delay behaves as one tick.
    c0 = timer_count;
    arm_valid = 4'b0100; arm_delay[2] = 32'd0;
    clr_stats();
    cyc();
    arm_valid = '0;
    run(10);
    check("zero_delay_fire_count", 32'(fire_cnt[2]), 32'd1);
    check("zero_delay_latency", 32'(fire_tc[2] >= c0 + 32'd2 && fire_tc[2] <= c0 + 32'd5), 32'd1);

    // Wrap-around: 0xFFFF_FFF0 + 0x20 -> deadline 0x10.
    irq_clear = 4'hF;
    cyc();
    irq_clear = '0;
    check("wrap_irq_cleared", 32'(irq_pending), 32'h0);
    timer_count = 32'hFFFF_FFF0;
    arm_valid = 4'b0001; arm_delay[0] = 32'h20;
    clr_stats();
    cyc();
    arm_valid = '0;
    run(45);
    check("wrap_fire_count", 32'(fire_cnt[0]), 32'd1);
    check("wrap_latency", 32'(fire_tc[0] >= 32'h11 && fire_tc[0] <= 32'h14), 32'd1);

    // Cancel in the exact cycle slot 1 is scanned expired.
    c0 = timer_count;
    arm_valid = 4'b0010; arm_delay[1] = 32'd5;
    clr_stats();
    cyc();
    arm_valid = '0;
    seek_scan(1, c0 + 32'd5, "cancel_reach_scan");
    check("cancel_armed_before", 32'(armed[1]), 32'd1);
    cancel = 4'b0010;
    cyc();
    cancel = '0;
    run(8);
    check("cancel_no_fire", 32'(fire_cnt[1]), 32'd0);
    check("cancel_no_irq", 32'(irq_pending[1]), 32'd0);
    check("cancel_idle", 32'(armed[1]), 32'd0);
    check("cancel_ready", 32'(arm_ready[1]), 32'd1);

    // All four slots armed together with delay 3.
    c0 = timer_count;
    watch_tc = c0 + 32'd3;
    arm_valid = 4'hF;
    for (int i = 0; i < 4; i++) arm_delay[i] = 32'd3;
    clr_stats();
    cyc();
    arm_valid = '0;
    run(12);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("all_fire_count_%0d", i), 32'(fire_cnt[i]), 32'd1);
      check($sformatf("all_latency_%0d", i),
            32'(fire_tc[i] >= c0 + 32'd4 && fire_tc[i] <= c0 + 32'd7), 32'd1);
    end
    check("all_trigger_count", 32'(itrig_cnt), 32'd4);
    check("all_order_size", 32'(fire_order.size()), 32'd4);
    if (fire_order.size() == 4) begin
      for (int k = 0; k < 4; k++)
        check($sformatf("all_order_%0d", k), 32'(fire_order[k]), 32'((watch_ptr + k) % 4));
    end

    // Sticky irq: clear colliding with a second fire of slot 3 loses.
    irq_clear = 4'hF;
    cyc();
    irq_clear = '0;
    arm_valid = 4'b1000; arm_delay[3] = 32'd2;
    clr_stats();
    cyc();
    arm_valid = '0;
    run(8);
    check("sticky_first_irq", 32'(irq_pending), 32'h8);
    c0 = timer_count;
    arm_valid = 4'b1000; arm_delay[3] = 32'd3;
    cyc();
    arm_valid = '0;
    dl = c0 + 32'd3;
    seek_scan(3, dl, "sticky_reach_scan");
    cyc();
    check("sticky_second_fire", 32'(fire), 32'h8);
    irq_clear = 4'b1000;
    cyc();
    irq_clear = '0;
    check("sticky_set_wins", 32'(irq_pending[3]), 32'd1);
    irq_clear = 4'b1000;
    cyc();
    irq_clear = '0;
    check("sticky_later_clear", 32'(irq_pending[3]), 32'd0);

    // Reset mid-operation drops armed alarms silently.
    arm_valid = 4'b0011; arm_delay[0] = 32'd10; arm_delay[1] = 32'd10;
    cyc();
    arm_valid = '0;
    run(2);
    check("rstmid_armed_before", 32'(armed), 32'h3);
    res = 1'b1;
    #1;
    check("rstmid_arm_ready_in_res", 32'(arm_ready), 32'h0);
    check("rstmid_trigger_in_res", 32'(interrupt_trigger), 32'h0);
    clr_stats();
    cyc();
    res = 1'b0;
    #1;
    check("rstmid_armed_after", 32'(armed), 32'h0);
    check("rstmid_arm_ready_after", 32'(arm_ready), 32'hF);
    check("rstmid_irq_after", 32'(irq_pending), 32'h0);
    run(20);
    check("rstmid_no_fire", 32'(fire_cnt[0] + fire_cnt[1]), 32'd0);
    check("rstmid_no_trigger", 32'(itrig_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
